// File: rtl/class_argmax_seq_pkg.sv
// rtl/class_argmax_seq_pkg.sv - shared constants and FSM encoding for the class argmax block
// Contents: default frame geometry, state encoding, most-negative score constant.
package class_argmax_seq_pkg;

  localparam int DEF_N_CLASSES = 10;
  localparam int DEF_SCORE_W   = 20;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t HOLD    = 2'd2;

  // Seed for the running maximum: any real score ties or beats it.
  localparam logic signed [DEF_SCORE_W-1:0] SCORE_MIN = {1'b1, {(DEF_SCORE_W-1){1'b0}}};

endpackage

// File: rtl/class_argmax_seq_argmax_update.sv
// rtl/class_argmax_seq_argmax_update.sv - combinational strict-greater argmax step
// Ports:
//   best_score/best_idx : current running maximum and its class index
//   s_score/cnt         : candidate score and its class index
//   next_score/next_idx : updated maximum; ties keep the incumbent (lower index)
module argmax_update #(
  parameter int SCORE_W = 20,
  parameter int IDX_W   = 4
) (
  input  logic signed [SCORE_W-1:0] best_score,
  input  logic        [IDX_W-1:0]   best_idx,
  input  logic signed [SCORE_W-1:0] s_score,
  input  logic        [IDX_W-1:0]   cnt,
  output logic signed [SCORE_W-1:0] next_score,
  output logic        [IDX_W-1:0]   next_idx
);

  logic take;

  assign take       = (s_score > best_score);
  assign next_score = take ? s_score : best_score;
  assign next_idx   = take ? cnt     : best_idx;

endmodule

// File: rtl/class_argmax_seq.sv
// rtl/class_argmax_seq.sv - serial argmax over one frame of signed class scores
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : pulse that (re)starts a frame
//   s_valid/s_score   : incoming class score, class order 0..N_CLASSES-1
//   s_ready           : high while collecting
//   m_valid/m_ready   : result handshake
//   m_class/m_score   : winning class index and its score
//   busy              : frame in progress
module class_argmax_seq
  import class_argmax_seq_pkg::*;
#(
  parameter int N_CLASSES = DEF_N_CLASSES,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int IDX_W     = $clog2(N_CLASSES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      s_valid,
  input  logic signed [SCORE_W-1:0] s_score,
  output logic                      s_ready,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic        [IDX_W-1:0]   m_class,
  output logic signed [SCORE_W-1:0] m_score,
  output logic                      busy
);

  localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic        [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CLASSES - 1);

  state_t                      state;
  logic        [IDX_W-1:0]     cnt;
  logic signed [SCORE_W-1:0]   best_score;
  logic        [IDX_W-1:0]     best_idx;
  logic signed [SCORE_W-1:0]   upd_score;
  logic        [IDX_W-1:0]     upd_idx;
  logic                        accept;

  assign s_ready = (state == COLLECT);
  assign busy    = (state == COLLECT);
  assign m_valid = (state == HOLD);
  assign accept  = s_valid && s_ready;

  argmax_update #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_update (
    .best_score (best_score),
    .best_idx   (best_idx),
    .s_score    (s_score),
    .cnt        (cnt),
    .next_score (upd_score),
    .next_idx   (upd_idx)
  );

  // m_class/m_score are separate from the running best so they stay put
  // while the next frame is being collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      m_class    <= '0;
      m_score    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= COLLECT;
            cnt        <= '0;
            best_score <= MIN_SCORE;
            best_idx   <= '0;
          end
        end
        COLLECT: begin
          if (start) begin
            // Abort: a score arriving with start is deliberately dropped.
            cnt        <= '0;
            best_score <= MIN_SCORE;
            best_idx   <= '0;
          end else if (accept) begin
            best_score <= upd_score;
            best_idx   <= upd_idx;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state   <= HOLD;
              m_class <= upd_idx;
              m_score <= upd_score;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            if (start) begin
              state      <= COLLECT;
              cnt        <= '0;
              best_score <= MIN_SCORE;
              best_idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_argmax_seq.sv
// tb/tb_class_argmax_seq.sv - scoreboard bench for class_argmax_seq
module tb_class_argmax_seq;
  import class_argmax_seq_pkg::*;

  typedef struct {
    int cls;
    int score;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               s_valid;
  logic signed [19:0] s_score;
  logic               s_ready;
  logic               m_valid;
  logic               m_ready;
  logic        [3:0]  m_class;
  logic signed [19:0] m_score;
  logic               busy;

  int checks;
  int errors;
  exp_t sb[$];

  class_argmax_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_score (s_score),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_class (m_class),
    .m_score (m_score),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops and compares one expected frame.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got class %0d score %0d with empty scoreboard", m_class, m_score);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_class", int'(m_class), e.cls);
        chk("sb_score", int'(m_score), e.score);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One score; s_ready is sampled before the accepting edge. A nonzero gap
  // idles s_valid with a large decoy score that must never be accepted.
  task automatic send(input int v, input int gap);
    s_valid = 1'b1;
    s_score = 20'(v);
    @(negedge clk);
    chk("s_ready_collect", int'(s_ready), 1);
    @(posedge clk);
    #1;
    if (gap > 0) begin
      s_valid = 1'b0;
      s_score = 20'sd300000;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int c, input int s);
    exp_t e;
    e.cls = c;
    e.score = s;
    sb.push_back(e);
  endtask

  int f1[10] = '{5, -3, 100, 7, 100, 0, -1, 2, 99, -50};
  int f3[10] = '{-10, 0, 1233, 5, -2000, 7, 1000, 12, 1233, 1234};
  int g3[10] = '{2, 0, 1, 3, 0, 2, 1, 0, 3, 1};
  int f4[10] = '{1, -5, 3, 9, 0, 2, 10, 10, -7, 4};
  int f5[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1};

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_score = '0;
    m_ready = 1'b1;

    #3;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_class", int'(m_class), 0);
    chk("rst_m_score", int'(m_score), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // s_valid in IDLE is ignored
    s_valid = 1'b1;
    s_score = 20'sd4000;
    @(negedge clk);
    chk("idle_s_ready", int'(s_ready), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    // Frame 1: back-to-back, tie keeps index 2
    push_exp(2, 100);
    pulse_start();
    chk("f1_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("f1_m_valid_early", int'(m_valid), 0);
      send(f1[i], (i == 9) ? 0 : 0);
    end
    s_valid = 1'b0;
    chk("f1_m_valid_latency", int'(m_valid), 1);
    chk("f1_busy_hold", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("f1_back_idle", int'(m_valid), 0);

    // Frame 2: all most-negative
    push_exp(0, int'(SCORE_MIN));
    pulse_start();
    for (int i = 0; i < 10; i++) send(-524288, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame 3: gapped s_valid, max at class 9, then HOLD with m_ready low
    m_ready = 1'b0;
    push_exp(9, 1234);
    pulse_start();
    for (int i = 0; i < 10; i++) send(f3[i], g3[i]);
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      @(negedge clk);
      chk("hold_m_valid", int'(m_valid), 1);
      chk("hold_m_class", int'(m_class), 9);
      chk("hold_m_score", int'(m_score), 1234);
      chk("hold_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_restart_busy", int'(busy), 1);
    chk("hold_restart_m_valid", int'(m_valid), 0);
    chk("hold_restart_keep_class", int'(m_class), 9);

    // Frame 4: abort after 4 scores, dropped score rides on the start cycle
    for (int i = 0; i < 4; i++) send((i == 0) ? 900 : i, 0);
    s_valid = 1'b1;
    s_score = 20'sd5000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(6, 10);
    for (int i = 0; i < 10; i++) send(f4[i], 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame 5: async reset mid-frame
    pulse_start();
    for (int i = 0; i < 3; i++) send(50 + 10 * i, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_s_ready", int'(s_ready), 0);
    chk("arst_m_valid", int'(m_valid), 0);
    chk("arst_m_class", int'(m_class), 0);
    chk("arst_m_score", int'(m_score), 0);
    s_score = 20'sd777;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_m_valid", int'(m_valid), 0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    push_exp(8, 9);
    pulse_start();
    for (int i = 0; i < 10; i++) send(f5[i], 0);
    s_valid = 1'b0;

    // Drain, bounded
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/class_argmax_seq.md
Name: class_argmax_seq

Overview:
- Downstream consumer of the output-layer int20 class-score registers.
- Accepts one signed score per class, serially, over a valid/ready stream, and tracks the running maximum and its index.
- After N_CLASSES scores it presents the winning class index and score on an output valid/ready handshake.
- Sits between the output-layer accumulator/score registers and the top-level result interface.

Parameters:
- N_CLASSES, 10, number of class scores per frame (>=2).
- SCORE_W, 20, signed score width.
- IDX_W, $clog2(N_CLASSES), class index width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  single-cycle pulse that begins a new frame
- s_valid  in  1  score present on s_score
- s_score  in  SCORE_W  signed class score, class order 0..N_CLASSES-1
- s_ready  out  1  block accepts a score this cycle
- m_valid  out  1  result available
- m_ready  in  1  result consumer ready
- m_class  out  IDX_W  index of the maximum score
- m_score  out  SCORE_W  signed maximum score
- busy  out  1  frame in progress (state COLLECT)

Behaviour:
- Reset: state IDLE; s_ready=0, m_valid=0, busy=0, m_class=0, m_score=0; internal counter=0, best_score=0, best_idx=0.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - s_ready=0; s_valid is ignored.
  - start -> COLLECT next cycle; cnt=0, best_score=most-negative (-2^(SCORE_W-1)), best_idx=0.
- COLLECT:
  - s_ready=1, busy=1.
  - Accept = s_valid & s_ready.
  - On accept: if s_score > best_score (signed, strict), then best_score<=s_score and best_idx<=cnt.
  - cnt increments on every accept.
  - Ties keep the lower index. A frame of all most-negative scores yields index 0.
  - Accept with cnt==N_CLASSES-1 -> HOLD. The compare on that last score is applied in the same cycle.
  - start in COLLECT aborts the frame: re-initialise as from IDLE, stay in COLLECT. If s_valid is also high that cycle, the score is dropped.
- HOLD:
  - m_valid=1; m_class/m_score are stable, driven from best_idx/best_score; s_ready=0.
  - Latency: m_valid rises the cycle after the last score is accepted.
  - m_valid & m_ready -> IDLE. m_class/m_score keep their last value until the next frame's completion.
  - start with m_ready in the same cycle -> COLLECT directly, re-initialised. start without m_ready is ignored.
- Arithmetic: signed compare only; no saturation or width growth.
- Counter: IDX_W bits; it never wraps because the FSM exits at N_CLASSES-1.
- Async reset mid-frame: immediate return to reset values; the partial frame is discarded.

Decomposition:
- Shared package:
  - SCORE_W and N_CLASSES defaults.
  - State enum {IDLE, COLLECT, HOLD}.
  - SCORE_MIN constant (most-negative score).
- Sub-module: argmax_update.
  - Purely combinational.
  - Inputs: best_score, best_idx, s_score, cnt.
  - Outputs: next best_score/best_idx with the strict-greater rule.
  - Reused by a future parallel argmax tree.

Test Plan:
- Reset then start, scores {5,-3,100,7,100,0,-1,2,99,-50} with s_valid held high -> m_valid 1 cycle after the 10th accept; m_class=2, m_score=100 (tie keeps index 2).
- All scores -524288 -> m_class=0, m_score=-524288.
- s_valid toggling with random gaps, max 1234 at class 9 -> m_class=9, m_score=1234; s_ready stays 1 throughout COLLECT; no score is double-counted.
- m_ready held low for 5 cycles in HOLD, start pulsed meanwhile -> m_valid and outputs stay stable, start is ignored; then m_ready=1 with start=1 -> COLLECT next cycle, m_valid=0.
- start asserted after 4 scores (max 900 so far), then 10 new scores with max 10 at class 6 -> m_class=6, m_score=10.
- rst_n asserted low after 3 scores -> all outputs 0 immediately, state IDLE; s_valid ignored until the next start.
